multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the existing single-cycle datapath (control decode, register file, ALU, data memory). It fetches one instruction over a ready-based instruction-memory handshake and latches it. It then walks the instruction through DECODE/EXEC/MEM/WB states, asserting each datapath strobe only in its own cycle, and waits on a data-memory ready handshake. It replaces the combinational control block when memories have variable latency.

---
 rtl/riscv_ctrl_pkg.sv | 53 +++++
 rtl/ctrl_decode.sv | 83 ++++++++
 rtl/multicycle_ctrl.sv | 137 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer:
//   - state_e   : sequencer states (encoding is visible on the debug port)
//   - iclass_e  : instruction class latched at DECODE
//   - OP_*      : supported major opcodes
//   - ALU_*     : ALUControl codes understood by the existing ALU
//   - alu_for_funct3 : maps an ALU funct3 to {supported, ALUControl}
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE   = 3'd0,
    CL_R      = 3'd1,
    CL_I      = 3'd2,
    CL_LOAD   = 3'd3,
    CL_STORE  = 3'd4,
    CL_BRANCH = 3'd5
  } iclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Bit 4 of the result flags a supported funct3; bits 3:0 are the ALU code.
  // sub_sel only matters for funct3 000 (R-type uses funct7[5], I-type passes 0).
  function automatic logic [4:0] alu_for_funct3(input logic [2:0] funct3,
                                                input logic       sub_sel);
    logic [4:0] r_sel;
    case (funct3)
      3'b000:  r_sel = {1'b1, (sub_sel ? ALU_SUB : ALU_ADD)};
      3'b111:  r_sel = {1'b1, ALU_AND};
      3'b110:  r_sel = {1'b1, ALU_OR};
      default: r_sel = 5'b0_0000;
    endcase
    return r_sel;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder for the multi-cycle sequencer.
// Ports:
//   i_ir        in  32  latched instruction word
//   o_class     out  3  instruction class (CL_NONE when unsupported)
//   o_alu_ctl   out  4  ALUControl code for EXEC onwards
//   o_alu_src   out  1  0 = readData2, 1 = immediate
//   o_illegal   out  1  encoding not supported by this datapath
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output iclass_e     o_class,
  output logic [3:0]  o_alu_ctl,
  output logic        o_alu_src,
  output logic        o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_alu_sel;
  logic       w_unused_bits;

  assign w_opcode = i_ir[6:0];
  assign w_funct3 = i_ir[14:12];

  // Register/immediate fields are consumed by the datapath, not the decoder.
  assign w_unused_bits = ^{i_ir[31], i_ir[29:15], i_ir[11:7]};

  always_comb begin
    o_class   = CL_NONE;
    o_alu_ctl = ALU_AND;
    o_alu_src = 1'b0;
    o_illegal = 1'b1;
    w_alu_sel = 5'b0_0000;
    case (w_opcode)
      OP_R: begin
        w_alu_sel = alu_for_funct3(w_funct3, i_ir[30]);
        if (w_alu_sel[4]) begin
          o_class   = CL_R;
          o_alu_ctl = w_alu_sel[3:0];
          o_illegal = 1'b0;
        end
      end
      OP_I: begin
        // ADDI has no subtract form, so funct7[5] is not consulted here.
        w_alu_sel = alu_for_funct3(w_funct3, 1'b0);
        if (w_alu_sel[4]) begin
          o_class   = CL_I;
          o_alu_ctl = w_alu_sel[3:0];
          o_alu_src = 1'b1;
          o_illegal = 1'b0;
        end
      end
      OP_LOAD: begin
        if (w_funct3 == 3'b011) begin
          o_class   = CL_LOAD;
          o_alu_ctl = ALU_ADD;
          o_alu_src = 1'b1;
          o_illegal = 1'b0;
        end
      end
      OP_STORE: begin
        if (w_funct3 == 3'b011) begin
          o_class   = CL_STORE;
          o_alu_ctl = ALU_ADD;
          o_alu_src = 1'b1;
          o_illegal = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (w_funct3 == 3'b000) begin
          o_class   = CL_BRANCH;
          o_alu_ctl = ALU_SUB;
          o_alu_src = 1'b0;
          o_illegal = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer driving the single-cycle datapath through
// FETCH/DECODE/EXEC/MEM/WB with ready handshakes on both memories.
// Ports:
//   clk, reset (async, active-low), run (start permit)
//   imem_req/imem_ready/inst  : instruction fetch handshake
//   ir                        : latched instruction
//   zero                      : ALU zero flag (branch resolve)
//   dmem_ready                : data access complete
//   MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg, ALUControl : datapath controls
//   pc_we, pc_src             : PC update strobe and select
//   illegal                   : sticky unsupported-encoding flag
//   instret                   : retired-instruction counter (wraps)
//   state                     : current state, debug
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [31:0]         inst,
  output logic [31:0]         ir,
  input  logic                zero,
  input  logic                dmem_ready,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic [3:0]          ALUControl,
  output logic                pc_we,
  output logic                pc_src,
  output logic                illegal,
  output logic [RETIRE_W-1:0] instret,
  output logic [2:0]          state
);

  localparam logic [RETIRE_W-1:0] INSTRET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_e                r_state;
  state_e                w_state_nxt;
  logic [31:0]           r_ir;
  iclass_e               r_class;
  logic [3:0]            r_alu_ctl;
  logic                  r_alu_src;
  logic                  r_illegal;
  logic [RETIRE_W-1:0]   r_instret;

  iclass_e               w_dec_class;
  logic [3:0]            w_dec_alu_ctl;
  logic                  w_dec_alu_src;
  logic                  w_dec_illegal;

  logic                  w_branch_exec;
  logic                  w_store_done;
  logic                  w_retire;

  ctrl_decode u_decode (
    .i_ir      (r_ir),
    .o_class   (w_dec_class),
    .o_alu_ctl (w_dec_alu_ctl),
    .o_alu_src (w_dec_alu_src),
    .o_illegal (w_dec_illegal)
  );

  assign w_branch_exec = (r_state == ST_EXEC) && (r_class == CL_BRANCH);
  // A store retires in the cycle its access completes, so the PC strobe has
  // to follow dmem_ready there; otherwise the PC would advance every MEM cycle.
  assign w_store_done  = (r_state == ST_MEM) && (r_class == CL_STORE) && dmem_ready;
  assign w_retire      = w_branch_exec || w_store_done || (r_state == ST_WB);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (run) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_ready) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = w_dec_illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if ((r_class == CL_LOAD) || (r_class == CL_STORE)) w_state_nxt = ST_MEM;
        else if (r_class != CL_BRANCH)                     w_state_nxt = ST_WB;
      end
      ST_MEM:    if (dmem_ready && (r_class == CL_LOAD)) w_state_nxt = ST_WB;
      ST_WB:     w_state_nxt = ST_WB;
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
    // run is sampled once more at retire: a late drop finishes the
    // instruction and parks in IDLE instead of fetching.
    if (w_retire) w_state_nxt = run ? ST_FETCH : ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_ir      <= 32'h0000_0000;
      r_class   <= CL_NONE;
      r_alu_ctl <= ALU_AND;
      r_alu_src <= 1'b0;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_FETCH) && imem_ready) r_ir <= inst;
      // Decode results are held from EXEC through MEM/WB so the ALU
      // address/result stays stable while the data memory is busy.
      if (r_state == ST_DECODE) begin
        r_class   <= w_dec_class;
        r_alu_ctl <= w_dec_alu_ctl;
        r_alu_src <= w_dec_alu_src;
        if (w_dec_illegal) r_illegal <= 1'b1;
      end else if (w_retire) begin
        r_alu_ctl <= ALU_AND;
        r_alu_src <= 1'b0;
      end
      if (w_retire) r_instret <= r_instret + INSTRET_ONE;
    end
  end

  assign imem_req   = (r_state == ST_FETCH);
  assign MemRead    = (r_state == ST_MEM) && (r_class == CL_LOAD);
  assign MemWrite   = (r_state == ST_MEM) && (r_class == CL_STORE);
  // Writes to x0 are dropped here so the register file never sees them.
  assign RegWrite   = (r_state == ST_WB) && (r_ir[11:7] != 5'd0);
  assign MemtoReg   = (r_state == ST_WB) && (r_class == CL_LOAD);
  assign pc_we      = w_retire;
  assign pc_src     = w_branch_exec && zero;
  assign ALUControl = r_alu_ctl;
  assign ALUSrc     = r_alu_src;
  assign ir         = r_ir;
  assign illegal    = r_illegal;
  assign instret    = r_instret;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Each scenario task drives a short
// per-cycle input table and compares a packed snapshot of the control outputs
// {state, imem_req, MemRead, MemWrite, RegWrite, MemtoReg, pc_we, pc_src,
//  ALUSrc, ALUControl} against hand-written expectations.
module tb_multicycle_ctrl;

  localparam int RW = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  // strobe order: imem_req MemRead MemWrite RegWrite MemtoReg pc_we pc_src
  localparam logic [6:0] SB_NONE = 7'b0000000, SB_REQ  = 7'b1000000,
                         SB_RD   = 7'b0100000, SB_WR   = 7'b0010000,
                         SB_WRDN = 7'b0010010, SB_WB   = 7'b0001010,
                         SB_WBLD = 7'b0001110, SB_PCWE = 7'b0000010,
                         SB_BRT  = 7'b0000011;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_SUB  = 32'h402081B3;
  localparam logic [31:0] W_OR   = 32'h0020E1B3;
  localparam logic [31:0] W_ANDI = 32'h0070F293;
  localparam logic [31:0] W_LD   = 32'h0080B283;
  localparam logic [31:0] W_SD   = 32'h0020B023;
  localparam logic [31:0] W_BEQ  = 32'h00208463;
  localparam logic [31:0] W_ILL  = 32'hFFFFFFFF;
  localparam logic [31:0] W_ADDI0 = 32'h00100013;

  logic          clk;
  logic          reset;
  logic          run;
  logic          imem_req;
  logic          imem_ready;
  logic [31:0]   inst;
  logic [31:0]   ir;
  logic          zero;
  logic          dmem_ready;
  logic          MemRead, MemWrite, RegWrite, ALUSrc, MemtoReg;
  logic [3:0]    ALUControl;
  logic          pc_we, pc_src, illegal;
  logic [RW-1:0] instret;
  logic [2:0]    state;

  int            n_cmp;
  int            n_fail;
  logic [RW-1:0] exp_instret;

  multicycle_ctrl #(.RETIRE_W(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .inst       (inst),
    .ir         (ir),
    .zero       (zero),
    .dmem_ready (dmem_ready),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .ALUControl (ALUControl),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .instret    (instret),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {state, imem_req, MemRead, MemWrite, RegWrite, MemtoReg, pc_we, pc_src,
            ALUSrc, ALUControl};
  endfunction

  function automatic logic [14:0] ev(input logic [2:0] st, input logic [6:0] sb,
                                     input logic src, input logic [3:0] alu);
    return {st, sb, src, alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: starting in IDLE, applies per-cycle inputs and records a
  // snapshot of the outputs in each of the n cycles. fv marks the cycles in
  // which inst carries the word; other cycles present junk.
  task automatic run_seq(input logic [31:0] word, input logic [0:7] fv,
                         input logic [0:7] imr, input logic [0:7] dmr,
                         input logic [0:7] zv, input logic [0:7] rv,
                         input int n, output logic [0:7][14:0] got);
    got = '0;
    run = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      imem_ready = imr[c];
      dmem_ready = dmr[c];
      zero       = zv[c];
      run        = rv[c];
      inst       = fv[c] ? word : 32'hDEAD_BEEF;
      #1;
      got[c] = obs();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1; inst = W_ADD;
    repeat (2) tick();
    #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs(), 15'h0); end
    n_cmp++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir got=%h exp=0", ir); end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    n_cmp++; if (instret !== '0) begin n_fail++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    run = 1'b0;
    reset = 1'b1;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL idle_after_reset got=%h exp=0", obs()); end
  endtask

  task automatic test_add();
    logic [0:7][14:0] exp, got;
    exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           ev(S_EXEC, SB_NONE, 1'b0, A_ADD), ev(S_WB, SB_WB, 1'b0, A_ADD), {4{15'h0}}};
    run_seq(W_ADD, 8'b10000000, 8'b11111111, 8'b00000000, 8'b00000000, 8'b11100000, 4, got);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (got[c] !== exp[c]) begin n_fail++; $display("FAIL add_c%0d got=%h exp=%h", c, got[c], exp[c]); end
    end
    exp_instret++;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL add_idle got=%h exp=0", obs()); end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL add_instret got=%0d exp=%0d", instret, exp_instret); end
    n_cmp++; if (ir !== W_ADD) begin n_fail++; $display("FAIL add_ir got=%h exp=%h", ir, W_ADD); end
  endtask

  task automatic test_alu_codes();
    logic [31:0]      words [3];
    logic [3:0]       alus  [3];
    logic             srcs  [3];
    logic [0:7][14:0] got;
    words[0] = W_SUB;  alus[0] = A_SUB; srcs[0] = 1'b0;
    words[1] = W_OR;   alus[1] = A_OR;  srcs[1] = 1'b0;
    words[2] = W_ANDI; alus[2] = A_AND; srcs[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_seq(words[i], 8'b10000000, 8'b11111111, 8'b00000000, 8'b00000000, 8'b11100000, 4, got);
      n_cmp++;
      if (got[2] !== ev(S_EXEC, SB_NONE, srcs[i], alus[i])) begin
        n_fail++; $display("FAIL alu%0d_exec got=%h exp=%h", i, got[2], ev(S_EXEC, SB_NONE, srcs[i], alus[i]));
      end
      n_cmp++;
      if (got[3] !== ev(S_WB, SB_WB, srcs[i], alus[i])) begin
        n_fail++; $display("FAIL alu%0d_wb got=%h exp=%h", i, got[3], ev(S_WB, SB_WB, srcs[i], alus[i]));
      end
      exp_instret++;
      tick(); #1;
      n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL alu%0d_idle got=%h exp=0", i, obs()); end
    end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL alu_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_load();
    logic [0:7][14:0] exp, got;
    exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           ev(S_EXEC, SB_NONE, 1'b1, A_ADD), ev(S_MEM, SB_RD, 1'b1, A_ADD),
           ev(S_MEM, SB_RD, 1'b1, A_ADD),    ev(S_MEM, SB_RD, 1'b1, A_ADD),
           ev(S_MEM, SB_RD, 1'b1, A_ADD),    ev(S_WB, SB_WBLD, 1'b1, A_ADD)};
    // dmem_ready is also raised in FETCH/DECODE where it must be ignored
    run_seq(W_LD, 8'b10000000, 8'b11111111, 8'b11000010, 8'b00000000, 8'b11111110, 8, got);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (got[c] !== exp[c]) begin n_fail++; $display("FAIL load_c%0d got=%h exp=%h", c, got[c], exp[c]); end
    end
    exp_instret++;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL load_idle got=%h exp=0", obs()); end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL load_instret got=%0d exp=%0d", instret, exp_instret); end
    n_cmp++; if (ir !== W_LD) begin n_fail++; $display("FAIL load_ir got=%h exp=%h", ir, W_LD); end
  endtask

  task automatic test_store();
    logic [0:7][14:0] exp, got;
    exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           ev(S_EXEC, SB_NONE, 1'b1, A_ADD), ev(S_MEM, SB_WR, 1'b1, A_ADD),
           ev(S_MEM, SB_WRDN, 1'b1, A_ADD),  {3{15'h0}}};
    run_seq(W_SD, 8'b10000000, 8'b11111111, 8'b00001000, 8'b00000000, 8'b11110000, 5, got);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (got[c] !== exp[c]) begin n_fail++; $display("FAIL store_c%0d got=%h exp=%h", c, got[c], exp[c]); end
    end
    exp_instret++;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL store_idle got=%h exp=0", obs()); end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL store_instret got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_branch();
    logic [0:7][14:0] exp, got;
    logic [0:7]       zv;
    for (int t = 0; t < 2; t++) begin
      // zero toggles in FETCH/DECODE too; only the EXEC value may reach pc_src
      zv = (t == 0) ? 8'b11100000 : 8'b11000000;
      exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
             ev(S_EXEC, (t == 0) ? SB_BRT : SB_PCWE, 1'b0, A_SUB), {5{15'h0}}};
      run_seq(W_BEQ, 8'b10000000, 8'b11111111, 8'b00000000, zv, 8'b11000000, 3, got);
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (got[c] !== exp[c]) begin n_fail++; $display("FAIL beq%0d_c%0d got=%h exp=%h", t, c, got[c], exp[c]); end
      end
      exp_instret++;
      tick(); #1;
      n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL beq%0d_idle got=%h exp=0", t, obs()); end
      n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL beq%0d_instret got=%0d exp=%0d", t, instret, exp_instret); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:7][14:0] exp, got;
    exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           ev(S_EXEC, SB_BRT, 1'b0, A_SUB),  ev(S_FETCH, SB_REQ, 1'b0, A_AND),
           ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           ev(S_EXEC, SB_PCWE, 1'b0, A_SUB), 15'h0};
    run_seq(W_BEQ, 8'b10001000, 8'b11101111, 8'b00000000, 8'b00100000, 8'b11111100, 7, got);
    for (int c = 0; c < 7; c++) begin
      n_cmp++;
      if (got[c] !== exp[c]) begin n_fail++; $display("FAIL b2b_c%0d got=%h exp=%h", c, got[c], exp[c]); end
    end
    exp_instret += 2;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL b2b_idle got=%h exp=0", obs()); end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_instret); end
    n_cmp++; if (ir !== W_BEQ) begin n_fail++; $display("FAIL b2b_ir got=%h exp=%h", ir, W_BEQ); end
  endtask

  task automatic test_illegal();
    logic [0:7][14:0] exp, got;
    exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           {6{ev(S_HALT, SB_NONE, 1'b0, A_AND)}}};
    run_seq(W_ILL, 8'b10000000, 8'b11111111, 8'b11111111, 8'b11111111, 8'b11111111, 8, got);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (got[c] !== exp[c]) begin n_fail++; $display("FAIL illegal_c%0d got=%h exp=%h", c, got[c], exp[c]); end
    end
    n_cmp++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got=%b exp=1", illegal); end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL illegal_instret got=%0d exp=%0d", instret, exp_instret); end
    reset = 1'b0;
    #1;
    n_cmp++; if (state !== S_IDLE) begin n_fail++; $display("FAIL halt_reset_state got=%0d exp=0", state); end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL halt_reset_illegal got=%b exp=0", illegal); end
    n_cmp++; if (instret !== '0) begin n_fail++; $display("FAIL halt_reset_instret got=%0d exp=0", instret); end
    n_cmp++; if (ir !== 32'h0) begin n_fail++; $display("FAIL halt_reset_ir got=%h exp=0", ir); end
    run = 1'b0;
    reset = 1'b1;
    exp_instret = '0;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL halt_reset_idle got=%h exp=0", obs()); end
  endtask

  task automatic test_run_drop();
    logic [0:7][14:0] exp, got;
    exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           ev(S_EXEC, SB_NONE, 1'b1, A_ADD), ev(S_WB, SB_PCWE, 1'b1, A_ADD), {4{15'h0}}};
    run_seq(W_ADDI0, 8'b10000000, 8'b11111111, 8'b00000000, 8'b00000000, 8'b11000000, 4, got);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (got[c] !== exp[c]) begin n_fail++; $display("FAIL rundrop_c%0d got=%h exp=%h", c, got[c], exp[c]); end
    end
    exp_instret++;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL rundrop_idle got=%h exp=0", obs()); end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL rundrop_instret got=%0d exp=%0d", instret, exp_instret); end
    tick(); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rundrop_stay got=%b exp=0", imem_req); end
  endtask

  task automatic test_instret_wrap();
    inst = W_BEQ; imem_ready = 1'b1; dmem_ready = 1'b0; zero = 1'b0; run = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick(); #1;
      n_cmp++;
      if (state !== S_FETCH || instret !== exp_instret) begin
        n_fail++; $display("FAIL wrap_k%0d state=%0d instret=%0d exp_state=1 exp_instret=%0d", k, state, instret, exp_instret);
      end
      tick(); tick();
      run = (k != 15);
      #1;
      n_cmp++; if (pc_we !== 1'b1) begin n_fail++; $display("FAIL wrap_pcwe_k%0d got=%b exp=1", k, pc_we); end
      exp_instret++;
    end
    tick(); #1;
    n_cmp++; if (state !== S_IDLE) begin n_fail++; $display("FAIL wrap_idle got=%0d exp=0", state); end
    n_cmp++; if (instret !== exp_instret) begin n_fail++; $display("FAIL wrap_final got=%0d exp=%0d", instret, exp_instret); end
  endtask

  task automatic test_reset_in_mem();
    logic [0:7][14:0] exp, got;
    exp = {ev(S_FETCH, SB_REQ, 1'b0, A_AND), ev(S_DECODE, SB_NONE, 1'b0, A_AND),
           ev(S_EXEC, SB_NONE, 1'b1, A_ADD), ev(S_MEM, SB_WR, 1'b1, A_ADD), {4{15'h0}}};
    run_seq(W_SD, 8'b10000000, 8'b11111111, 8'b00000000, 8'b00000000, 8'b11111111, 4, got);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (got[c] !== exp[c]) begin n_fail++; $display("FAIL rstmem_c%0d got=%h exp=%h", c, got[c], exp[c]); end
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL rstmem_outputs got=%h exp=0", obs()); end
    n_cmp++; if (instret !== '0) begin n_fail++; $display("FAIL rstmem_instret got=%0d exp=0", instret); end
    n_cmp++; if (ir !== 32'h0) begin n_fail++; $display("FAIL rstmem_ir got=%h exp=0", ir); end
    run = 1'b0;
    reset = 1'b1;
    exp_instret = '0;
    tick(); #1;
    n_cmp++; if (obs() !== 15'h0) begin n_fail++; $display("FAIL rstmem_idle got=%h exp=0", obs()); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    exp_instret = '0;
    test_reset();
    test_add();
    test_alu_codes();
    test_load();
    test_store();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_run_drop();
    test_instret_wrap();
    test_reset_in_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
